// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with a one-word holding register and error reporting
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_rx_in      asynchronous serial line, idle high
//   i_rx_ready   consumer accepts o_rx_data when o_rx_valid && i_rx_ready
//   o_rx_data    received word, LSB first on the line
//   o_rx_valid   o_rx_data holds an unconsumed word
//   o_busy       receiver is inside a frame
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_overrun    one-cycle pulse, good frame dropped because the holding register was full
//   o_err_count  saturating error count, only counts when UART_RX_ERR_CNT_EN is defined
module uart_rx_ctrl #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx_in,
    input  logic             i_rx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic [7:0]       o_err_count
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic [DW-1:0]    r_div;
    logic [TW-1:0]    r_tcnt;
    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_shift;
    logic             w_rx_s;
    logic             w_tick;
    logic             w_smp;
    logic             w_start;
    logic             w_stop_smp;
    logic             w_hs;
    logic             w_load;

    assign w_rx_s     = r_sync[1];
    assign w_tick     = r_div == DW'(CLK_DIV - 1);
    // START samples half a bit in; DATA and STOP sample a full bit after the previous sample
    assign w_smp      = w_tick && r_state != IDLE &&
                        r_tcnt == (r_state == START ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1));
    assign w_stop_smp = r_state == STOP && w_smp;
    assign w_hs       = o_rx_valid && i_rx_ready;
    assign w_load     = w_stop_smp && w_rx_s && (!o_rx_valid || i_rx_ready);
    assign o_busy     = r_state != IDLE;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = r_rx_prev && !w_rx_s;
                w_next  = w_start ? START : IDLE;
            end
            START:   w_next = w_smp ? (w_rx_s ? IDLE : DATA) : START;
            DATA:    w_next = (w_smp && r_bcnt == BW'(WIDTH - 1)) ? STOP : DATA;
            default: w_next = w_smp ? IDLE : STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_rx_prev   <= 1'b1;
            r_div       <= '0;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_rx_in};
            r_rx_prev   <= w_rx_s;
            r_div       <= (w_start || w_tick) ? '0 : r_div + DW'(1);
            r_tcnt      <= (w_start || w_smp) ? '0 : (w_tick ? r_tcnt + TW'(1) : r_tcnt);
            if (r_state == DATA && w_smp) begin
                r_shift <= WIDTH'({w_rx_s, r_shift} >> 1);
                r_bcnt  <= r_bcnt == BW'(WIDTH - 1) ? '0 : r_bcnt + BW'(1);
            end
            if (w_load) o_rx_data <= r_shift;
            // a load in the same cycle as a handshake keeps valid high
            o_rx_valid  <= w_load || (o_rx_valid && !w_hs);
            o_frame_err <= w_stop_smp && !w_rx_s;
            o_overrun   <= w_stop_smp && w_rx_s && o_rx_valid && !i_rx_ready;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             r_err_cnt <= 8'd0;
        else if ((o_frame_err || o_overrun) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_err_count = r_err_cnt;
`else
    assign o_err_count = 8'd0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random frames checked against a word-level receiver model
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx_in = 1'b1;
    logic       i_rx_ready = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;
    logic [7:0] o_err_count;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.WIDTH(8), .OVERSAMPLE(16), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .i_rx_in(i_rx_in), .i_rx_ready(i_rx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_err_count(o_err_count)
    );

    int         compared = 0;
    int         mismatched = 0;
    int         fe_cnt = 0, ov_cnt = 0, fe_long = 0, ov_long = 0;
    logic       fe_prev = 1'b0, ov_prev = 1'b0;
    bit         busy_seen = 1'b0;
    logic [7:0] got_q[$];

    int         exp_fe = 0, exp_ov = 0, exp_err = 0;
    logic [7:0] exp_q[$];
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always @(negedge clk) begin
        #1;
        if (o_frame_err) fe_cnt++;
        if (o_overrun) ov_cnt++;
        if (o_frame_err && fe_prev) fe_long++;
        if (o_overrun && ov_prev) ov_long++;
        fe_prev = o_frame_err;
        ov_prev = o_overrun;
        if (o_busy) busy_seen = 1'b1;
        if (o_rx_valid && i_rx_ready) got_q.push_back(o_rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] err_exp();
`ifdef UART_RX_ERR_CNT_EN
        return exp_err > 255 ? 255 : exp_err;
`else
        return 0;
`endif
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit stop, input bit r);
        if (hold_v && r) begin
            exp_q.push_back(hold_d);
            hold_v = 1'b0;
        end
        if (!stop) begin
            exp_fe++;
            exp_err++;
        end else if (hold_v) begin
            exp_ov++;
            exp_err++;
        end else if (r) exp_q.push_back(d);
        else begin
            hold_v = 1'b1;
            hold_d = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_rx_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int rdy_at, output int ov_at);
        ov_at = -1;
        for (int c = 0; c < 640; c++) begin
            @(negedge clk);
            if (o_overrun && ov_at < 0) ov_at = c;
            i_rx_in = c < 64 ? 1'b0 : (c < 576 ? d[(c - 64) / 64] : stop);
            if (rdy_at >= 0) i_rx_ready = (c == rdy_at);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_words"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        check({tag, "_fe"}, fe_cnt, exp_fe);
        check({tag, "_ov"}, ov_cnt, exp_ov);
        check({tag, "_fe_width"}, fe_long, 0);
        check({tag, "_ov_width"}, ov_long, 0);
        check({tag, "_errcnt"}, o_err_count, err_exp());
        check({tag, "_valid"}, o_rx_valid, hold_v);
        if (hold_v) check({tag, "_data"}, o_rx_data, hold_d);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int         ov_at, dummy;
        logic [7:0] d;
        bit         stop, r;
        repeat (3) @(negedge clk);
        check("rst_data", o_rx_data, 0);
        check("rst_valid", o_rx_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_fe", o_frame_err, 0);
        check("rst_ov", o_overrun, 0);
        check("rst_errcnt", o_err_count, 0);
        rst = 1'b0;
        idle(20);

        i_rx_ready = 1'b1;
        model_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, -1, dummy);
        idle(10);
        check_all("a5");

        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            i_rx_in = 1'b0;
        end
        idle(100);
        check("glitch_start", busy_seen, 1);
        check_all("glitch");

        model_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, -1, dummy);
        idle(10);
        check_all("stop_low");

        i_rx_ready = 1'b0;
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, -1, dummy);
        idle(10);
        check_all("hold_11");
        model_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, -1, ov_at);
        idle(10);
        check_all("overrun");
        check("overrun_seen", ov_at >= 0, 1);

        exp_q.push_back(hold_d);
        hold_d = 8'h22;
        send_frame(8'h22, 1'b1, ov_at - 1, dummy);
        idle(10);
        check_all("same_cycle");

        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            i_rx_in = c < 64 ? 1'b0 : 1'b1;
        end
        check("mid_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", o_rx_data, 0);
        check("mid_rst_valid", o_rx_valid, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_errcnt", o_err_count, 0);
        hold_v = 1'b0;
        exp_err = 0;
        @(negedge clk);
        i_rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        check_all("after_rst");
        i_rx_ready = 1'b1;
        model_frame(8'h5A, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, -1, dummy);
        idle(10);
        check_all("5a");

        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            stop = ($urandom % 4) != 0;
            r = 1'($urandom % 2);
            i_rx_ready = r;
            model_frame(d, stop, r);
            send_frame(d, stop, -1, dummy);
            idle(8 + int'($urandom % 20));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, data bits per frame.
REQ-002: Parameter OVERSAMPLE, default 16, oversample ticks per bit; even, >=4.
REQ-003: Parameter CLK_DIV, default 27, clk cycles per oversample tick; >=1.
REQ-004: clk  input  1  clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, asynchronous, active-high.
REQ-006: rx_in  input  1  asynchronous serial line; idle high.
REQ-007: rx_data  output  WIDTH  received data word, LSB first on line.
REQ-008: rx_valid  output  1  rx_data holds an unconsumed word.
REQ-009: rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-010: busy  output  1  high in any state other than IDLE.
REQ-011: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012: overrun  output  1  one-cycle pulse: good frame dropped, holding register full.
REQ-013: err_count  output  8  saturating error count (see Configuration).

Function
REQ-014: rx_in shall pass through a 2-flop synchronizer; only its output (rx_s) is used internally.
REQ-015: A tick divider shall assert a one-cycle tick every CLK_DIV clk cycles, free-running, restarting at count 0 on each IDLE->START transition.
REQ-016: States: IDLE, START, DATA, STOP.
REQ-017: IDLE: rx_s high->low edge -> START, tick counter cleared.
REQ-018: START: after OVERSAMPLE/2 ticks, sample rx_s; low -> DATA; high -> IDLE (glitch rejected, no error).
REQ-019: DATA: sample rx_s every OVERSAMPLE ticks (mid-bit), shift in LSB first; after WIDTH samples -> STOP.
REQ-020: STOP: sample rx_s after OVERSAMPLE ticks; -> IDLE at that sample cycle (half stop bit, allows resync).
REQ-021: Stop sample high, rx_valid low or handshake this cycle: load rx_data, assert rx_valid next cycle.
REQ-022: Stop sample high, rx_valid high, rx_ready low: drop new word, keep rx_data, pulse overrun.
REQ-023: Stop sample low: pulse frame_err, discard word, rx_valid/rx_data unchanged.
REQ-024: rx_valid shall clear the cycle after rx_valid && rx_ready unless a new word loads the same cycle (REQ-021), then stays high.
REQ-025: rx_data shall be stable while rx_valid is high.
REQ-026: Bit/tick counters sized $clog2 of max value +1; no wrap within a frame.

Reset
REQ-027: rst shall force IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, busy 0, frame_err 0, overrun 0, err_count 0.
REQ-028: rst mid-frame shall abandon the frame with no output pulse; reception restarts on next falling edge after release.

Configuration
REQ-029: Macro UART_RX_ERR_CNT_EN defined: err_count increments by 1 on each frame_err or overrun pulse, saturating at 255, cleared only by rst.
REQ-030: UART_RX_ERR_CNT_EN undefined: err_count tied to 0, no counter logic; all other behaviour identical.

Verification (CLK_DIV=4, OVERSAMPLE=16 -> 64 clk/bit)
REQ-031: Frame 0xA5, 8N1, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, no errors, busy low after mid-stop.
REQ-032: 20-clk low glitch on idle line -> START then IDLE, no rx_valid, no frame_err.
REQ-033: Frame 0x3C with stop bit low -> frame_err one pulse, rx_valid stays 0; err_count=1 with macro, 0 without.
REQ-034: Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11 retained, overrun one pulse at second stop sample.
REQ-035: rx_ready asserted same cycle as 0x22 stop sample with 0x11 held -> 0x11 consumed, rx_data=0x22, rx_valid stays 1, no overrun.
REQ-036: rst asserted mid-DATA of 0xFF -> all outputs 0 immediately; next frame 0x5A received correctly.
